// File: rtl/psg_pkg.sv
// psg_pkg: byte field layout, channel constants and reset values for the PSG write port
package psg_pkg;
  localparam int LATCH_BIT = 7;
  localparam int CH_HI = 6;
  localparam int CH_LO = 5;
  localparam int TYPE_BIT = 4;
  localparam logic [1:0] TONE_CH0 = 2'd0;
  localparam logic [1:0] NOISE_CHANNEL = 2'd3;
  localparam logic [3:0] ATTENUATION_OFF = 4'hF;
  localparam logic [9:0] TONE_RESET = 10'd0;
  typedef struct packed {
    logic [1:0] channel;
    logic       is_attenuation;
  } latched_t;
  localparam latched_t LATCHED_RESET = '{channel: TONE_CH0, is_attenuation: 1'b0};
  function automatic logic is_noise(latched_t l);
    return l.channel == NOISE_CHANNEL && !l.is_attenuation;
  endfunction
endpackage

// File: rtl/psg_bus_interface_write_ready_timer.sv
// write_ready_timer: busy counter that holds ready low for a fixed number of cycles after each write
module write_ready_timer #(
  parameter int WRITE_BUSY_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic ready
);
  localparam int CW = WRITE_BUSY_CYCLES > 0 ? $clog2(WRITE_BUSY_CYCLES + 1) : 1;
  logic [CW-1:0] r_count;
  // reload on accept, otherwise count down and stick at zero
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (accept) r_count <= CW'(WRITE_BUSY_CYCLES);
    else if (r_count != '0) r_count <= r_count - CW'(1);
  assign ready = r_count == '0;
endmodule

// File: rtl/psg_bus_interface.sv
// psg_bus_interface: SN76489 latch/data byte decoder and register file with ready pacing
module psg_bus_interface
  import psg_pkg::*;
#(
  parameter int WRITE_BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       write,
  output logic       ready,
  output logic [9:0] tone_freq_0,
  output logic [9:0] tone_freq_1,
  output logic [9:0] tone_freq_2,
  output logic [2:0] noise_control,
  output logic [3:0] attenuation_0,
  output logic [3:0] attenuation_1,
  output logic [3:0] attenuation_2,
  output logic [3:0] attenuation_3,
  output logic       restart_noise
);
  logic [9:0] r_tone [3];
  logic [3:0] r_att [4];
  logic [2:0] r_noise;
  latched_t   r_latched;
  logic       r_restart;
  logic       w_accept;
  logic       w_latch;
  latched_t   w_target;
  write_ready_timer #(.WRITE_BUSY_CYCLES(WRITE_BUSY_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .accept(w_accept),
    .ready(ready)
  );
  assign w_accept = write & ready;
  assign w_latch = data[LATCH_BIT];
  // a latch byte names its own target; a data byte reuses the last latched one
  assign w_target = w_latch ? '{channel: data[CH_HI:CH_LO], is_attenuation: data[TYPE_BIT]} : r_latched;
  // register file update, latched target tracking and noise restart pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 3; i++) r_tone[i] <= TONE_RESET;
      for (int i = 0; i < 4; i++) r_att[i] <= ATTENUATION_OFF;
      r_noise <= 3'b000;
      r_latched <= LATCHED_RESET;
      r_restart <= 1'b0;
    end else begin
      r_restart <= w_accept && is_noise(w_target);
      if (w_accept) begin
        r_latched <= w_target;
        if (w_target.is_attenuation) r_att[w_target.channel] <= data[3:0];
        else if (is_noise(w_target)) r_noise <= data[2:0];
        else if (w_latch) r_tone[w_target.channel][3:0] <= data[3:0];
        else r_tone[w_target.channel][9:4] <= data[5:0];
      end
    end
  assign tone_freq_0 = r_tone[0];
  assign tone_freq_1 = r_tone[1];
  assign tone_freq_2 = r_tone[2];
  assign noise_control = r_noise;
  assign attenuation_0 = r_att[0];
  assign attenuation_1 = r_att[1];
  assign attenuation_2 = r_att[2];
  assign attenuation_3 = r_att[3];
  assign restart_noise = r_restart;
endmodule

// File: tb/tb_psg_bus_interface.sv
// tb_psg_bus_interface: directed byte writes with a scoreboard checked when ready drops after each accept
module tb_psg_bus_interface;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       write = 1'b0;
  logic       ready;
  logic [9:0] tone_freq_0, tone_freq_1, tone_freq_2;
  logic [2:0] noise_control;
  logic [3:0] attenuation_0, attenuation_1, attenuation_2, attenuation_3;
  logic       restart_noise;
  typedef struct {
    int         id;
    logic [9:0] v;
    logic       rs;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_ready = 1'b1;
  logic chk_pulse = 1'b0;

  psg_bus_interface #(.WRITE_BUSY_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .data(data), .write(write), .ready(ready),
    .tone_freq_0(tone_freq_0), .tone_freq_1(tone_freq_1), .tone_freq_2(tone_freq_2),
    .noise_control(noise_control),
    .attenuation_0(attenuation_0), .attenuation_1(attenuation_1),
    .attenuation_2(attenuation_2), .attenuation_3(attenuation_3),
    .restart_noise(restart_noise)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] reg_of(int id);
    case (id)
      0: return tone_freq_0;
      1: return tone_freq_1;
      2: return tone_freq_2;
      3: return {7'd0, noise_control};
      4: return {6'd0, attenuation_0};
      5: return {6'd0, attenuation_1};
      6: return {6'd0, attenuation_2};
      default: return {6'd0, attenuation_3};
    endcase
  endfunction

  task automatic chk(input string n, input logic [9:0] a, input logic [9:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_all_reset(input string n);
    for (int i = 0; i < 3; i++) chk({n, "_tone"}, reg_of(i), 10'h000);
    chk({n, "_noise"}, reg_of(3), 10'h000);
    for (int i = 4; i < 8; i++) chk({n, "_att"}, reg_of(i), 10'h00F);
    chk({n, "_ready"}, {9'd0, ready}, 10'd1);
    chk({n, "_restart"}, {9'd0, restart_noise}, 10'd0);
  endtask

  task automatic send(input logic [7:0] d, input int id, input logic [9:0] v, input logic rs);
    int k = 0;
    @(negedge clk);
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", {9'd0, ready}, 10'd1);
    else begin
      exp_q.push_back('{id: id, v: v, rs: rs});
      data = d;
      write = 1'b1;
      @(posedge clk);
      #1 write = 1'b0;
    end
  endtask

  // monitor: each falling ready marks an accepted write whose result is now visible
  always @(negedge clk) begin
    if (chk_pulse) begin
      chk("restart_one_cycle", {9'd0, restart_noise}, 10'd0);
      chk_pulse = 1'b0;
    end
    if (prev_ready && !ready) begin
      if (exp_q.size() == 0) chk("unexpected_accept", 10'd1, 10'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("reg%0d", mon_e.id), reg_of(mon_e.id), mon_e.v);
        chk("restart", {9'd0, restart_noise}, {9'd0, mon_e.rs});
        chk_pulse = 1'b1;
      end
    end
    prev_ready = ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_reset("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_reset("idle");
    send(8'h8E, 0, 10'h00E, 1'b0);
    send(8'h0F, 0, 10'h0FE, 1'b0);
    send(8'h7F, 0, 10'h3FE, 1'b0);
    chk("tone1_kept", tone_freq_1, 10'h000);
    chk("tone2_kept", tone_freq_2, 10'h000);
    send(8'hE5, 3, 10'h005, 1'b1);
    send(8'h02, 3, 10'h002, 1'b1);
    send(8'hB3, 5, 10'h003, 1'b0);
    send(8'h09, 5, 10'h009, 1'b0);
    send(8'h90, 4, 10'h000, 1'b0);
    @(negedge clk);
    exp_q.push_back('{id: 4, v: 10'h001, rs: 1'b0});
    data = 8'h91;
    write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("busy_ready_low", {9'd0, ready}, 10'd0);
      chk("busy_att0_held", {6'd0, attenuation_0}, 10'h000);
      @(negedge clk);
    end
    chk("ready_after_32", {9'd0, ready}, 10'd1);
    @(posedge clk);
    #1 write = 1'b0;
    send(8'hE5, 3, 10'h005, 1'b1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_reset("async_reset");
    @(negedge clk);
    reset = 1'b0;
    send(8'h0A, 0, 10'h0A0, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 10'(exp_q.size()), 10'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
